// File: rtl/geofence_eval.sv
// Geofence responder: collects six receiver samples, orders them into a convex ring around
// the first sample and decides whether the object lies inside via triangle-area comparison.
module geofence_eval #(
  parameter int XY_W = 10,
  parameter int R_W  = 11,
  parameter int NPTS = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XY_W-1:0] X,
  input  logic [XY_W-1:0] Y,
  input  logic [R_W-1:0]  R,
  output logic            valid,
  output logic            is_inside
);

  localparam int DW    = XY_W + 1;
  localparam int PW    = 2 * DW;
  localparam int CW    = PW + 1;
  localparam int M_W   = 2 * XY_W;
  localparam int SQ_W  = M_W + 1;
  localparam int S_W   = R_W + 2;
  localparam int P_W   = 4 * S_W;
  localparam int RT_W  = P_W / 2;
  localparam int REM_W = RT_W + 2;
  localparam int T_W   = RT_W + 3;
  localparam int A_W   = M_W + 4;

  typedef enum logic [3:0] {
    S_LOAD, S_SORT, S_AREA, S_EDGE, S_CROOT, S_SEMI, S_MUL, S_TROOT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             slot_q, slot_d;
  logic [2:0]             sort_i_q, sort_i_d;
  logic [2:0]             sort_lim_q, sort_lim_d;
  logic [2:0]             idx_q, idx_d;
  logic [4:0]             step_q, step_d;
  logic [XY_W-1:0]        x_q [NPTS];
  logic [XY_W-1:0]        x_d [NPTS];
  logic [XY_W-1:0]        y_q [NPTS];
  logic [XY_W-1:0]        y_d [NPTS];
  logic [R_W-1:0]         r_q [NPTS];
  logic [R_W-1:0]         r_d [NPTS];
  logic signed [A_W-1:0]  acc_q, acc_d;
  logic [T_W-1:0]         tsum_q, tsum_d;
  logic [S_W-1:0]         s_q, s_d, fa_q, fa_d, fb_q, fb_d, fc_q, fc_d;
  logic [P_W-1:0]         prod_q, prod_d;
  logic [P_W-1:0]         rad_q, rad_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [RT_W-1:0]        root_q, root_d;
  logic                   valid_q, valid_d;
  logic                   inside_q, inside_d;

  function automatic logic [S_W-1:0] pos_sub(input logic [S_W-1:0] a, input logic [S_W-1:0] b);
    return (a > b) ? (a - b) : {S_W{1'b0}};
  endfunction

  // Compare-swap helpers: angular order of slots sort_i, sort_i+1 around pivot slot 0.
  logic [2:0]             sb_s;
  logic signed [DW-1:0]   dxa_s, dya_s, dxb_s, dyb_s;
  logic signed [PW-1:0]   pa_s, pb_s;
  logic signed [CW-1:0]   cross_s;
  assign sb_s    = sort_i_q + 3'd1;
  assign dxa_s   = $signed({1'b0, x_q[sort_i_q]}) - $signed({1'b0, x_q[0]});
  assign dya_s   = $signed({1'b0, y_q[sort_i_q]}) - $signed({1'b0, y_q[0]});
  assign dxb_s   = $signed({1'b0, x_q[sb_s]}) - $signed({1'b0, x_q[0]});
  assign dyb_s   = $signed({1'b0, y_q[sb_s]}) - $signed({1'b0, y_q[0]});
  assign pa_s    = PW'(dxa_s) * PW'(dyb_s);
  assign pb_s    = PW'(dxb_s) * PW'(dya_s);
  assign cross_s = CW'(pa_s) - CW'(pb_s);

  logic [2:0]             nxt_s;
  logic [M_W-1:0]         m1_s, m2_s, dx2_s, dy2_s;
  logic signed [M_W:0]    term_s;
  logic [XY_W-1:0]        adx_s, ady_s;
  logic [SQ_W-1:0]        radc_s;
  assign nxt_s  = (idx_q == 3'd5) ? 3'd0 : (idx_q + 3'd1);
  assign m1_s   = M_W'(x_q[idx_q]) * M_W'(y_q[nxt_s]);
  assign m2_s   = M_W'(x_q[nxt_s]) * M_W'(y_q[idx_q]);
  assign term_s = $signed({1'b0, m1_s}) - $signed({1'b0, m2_s});
  assign adx_s  = (x_q[idx_q] >= x_q[nxt_s]) ? (x_q[idx_q] - x_q[nxt_s]) : (x_q[nxt_s] - x_q[idx_q]);
  assign ady_s  = (y_q[idx_q] >= y_q[nxt_s]) ? (y_q[idx_q] - y_q[nxt_s]) : (y_q[nxt_s] - y_q[idx_q]);
  assign dx2_s  = M_W'(adx_s) * M_W'(adx_s);
  assign dy2_s  = M_W'(ady_s) * M_W'(ady_s);
  assign radc_s = SQ_W'(dx2_s) + SQ_W'(dy2_s);

  logic [S_W-1:0]         c_s, sum3_s, semi_s;
  logic [P_W-1:0]         mul_a_s, mul_b_s;
  assign c_s     = S_W'(root_q);
  assign sum3_s  = S_W'(r_q[idx_q]) + S_W'(r_q[nxt_s]) + c_s;
  assign semi_s  = sum3_s >> 1;
  assign mul_a_s = (step_q == 5'd0) ? P_W'(s_q) : prod_q;
  assign mul_b_s = (step_q == 5'd0) ? P_W'(fa_q) : ((step_q == 5'd1) ? P_W'(fb_q) : P_W'(fc_q));

  // One restoring square-root digit per cycle; radicand is consumed two bits at a time from the top.
  logic [REM_W+1:0]       rem_sh_s, trial_s;
  logic                   ge_s;
  logic [REM_W-1:0]       rem_nx_s;
  logic [RT_W-1:0]        root_nx_s;
  assign rem_sh_s  = {rem_q, rad_q[P_W-1 -: 2]};
  assign trial_s   = {2'b00, root_q, 2'b01};
  assign ge_s      = (rem_sh_s >= trial_s);
  assign rem_nx_s  = ge_s ? REM_W'(rem_sh_s - trial_s) : REM_W'(rem_sh_s);
  assign root_nx_s = {root_q[RT_W-2:0], ge_s};

  logic [A_W-1:0]         mag_s, hex_s;
  assign mag_s = acc_q[A_W-1] ? A_W'(-acc_q) : A_W'(acc_q);
  assign hex_s = mag_s >> 1;

  // Next-state and datapath update for the load / sort / area / triangle sequence.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    sort_i_d   = sort_i_q;
    sort_lim_d = sort_lim_q;
    idx_d      = idx_q;
    step_d     = step_q;
    x_d        = x_q;
    y_d        = y_q;
    r_d        = r_q;
    acc_d      = acc_q;
    tsum_d     = tsum_q;
    s_d        = s_q;
    fa_d       = fa_q;
    fb_d       = fb_q;
    fc_d       = fc_q;
    prod_d     = prod_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    valid_d    = 1'b0;
    inside_d   = inside_q;
    case (state_q)
      S_LOAD: begin
        x_d[slot_q] = X;
        y_d[slot_q] = Y;
        r_d[slot_q] = R;
        if (slot_q == 3'd5) begin
          slot_d     = 3'd0;
          sort_i_d   = 3'd1;
          sort_lim_d = 3'd4;
          state_d    = S_SORT;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      S_SORT: begin
        if (cross_s[CW-1]) begin
          x_d[sort_i_q] = x_q[sb_s];
          x_d[sb_s]     = x_q[sort_i_q];
          y_d[sort_i_q] = y_q[sb_s];
          y_d[sb_s]     = y_q[sort_i_q];
          r_d[sort_i_q] = r_q[sb_s];
          r_d[sb_s]     = r_q[sort_i_q];
        end else begin
          x_d[sort_i_q] = x_q[sort_i_q];
        end
        if (sort_i_q == sort_lim_q) begin
          sort_i_d = 3'd1;
          if (sort_lim_q == 3'd1) begin
            idx_d   = 3'd0;
            acc_d   = '0;
            state_d = S_AREA;
          end else begin
            sort_lim_d = sort_lim_q - 3'd1;
          end
        end else begin
          sort_i_d = sort_i_q + 3'd1;
        end
      end
      S_AREA: begin
        acc_d = acc_q + A_W'(term_s);
        if (idx_q == 3'd5) begin
          idx_d   = 3'd0;
          tsum_d  = '0;
          state_d = S_EDGE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_EDGE: begin
        // Odd-width radicand is placed so an even number of zero bits trails it.
        rad_d   = P_W'(radc_s) << (P_W - SQ_W - 1);
        rem_d   = '0;
        root_d  = '0;
        step_d  = 5'd10;
        state_d = S_CROOT;
      end
      S_CROOT: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_nx_s;
        root_d = root_nx_s;
        if (step_q == 5'd0) begin
          state_d = S_SEMI;
        end else begin
          step_d = step_q - 5'd1;
        end
      end
      S_SEMI: begin
        s_d     = semi_s;
        fa_d    = pos_sub(semi_s, S_W'(r_q[idx_q]));
        fb_d    = pos_sub(semi_s, S_W'(r_q[nxt_s]));
        fc_d    = pos_sub(semi_s, c_s);
        step_d  = 5'd0;
        state_d = S_MUL;
      end
      S_MUL: begin
        prod_d = mul_a_s * mul_b_s;
        if (step_q == 5'd2) begin
          rad_d   = mul_a_s * mul_b_s;
          rem_d   = '0;
          root_d  = '0;
          step_d  = 5'd25;
          state_d = S_TROOT;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      S_TROOT: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_nx_s;
        root_d = root_nx_s;
        if (step_q == 5'd0) begin
          tsum_d = tsum_q + T_W'(root_nx_s);
          if (idx_q == 3'd5) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_EDGE;
          end
        end else begin
          step_d = step_q - 5'd1;
        end
      end
      S_DONE: begin
        valid_d  = 1'b1;
        inside_d = (tsum_q <= T_W'(hex_s));
        slot_d   = 3'd0;
        state_d  = S_LOAD;
      end
      default: begin
        state_d = S_LOAD;
        slot_d  = 3'd0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any object in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD;
      slot_q     <= 3'd0;
      sort_i_q   <= 3'd1;
      sort_lim_q <= 3'd4;
      idx_q      <= 3'd0;
      step_q     <= 5'd0;
      for (int k = 0; k < NPTS; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        r_q[k] <= '0;
      end
      acc_q    <= '0;
      tsum_q   <= '0;
      s_q      <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      fc_q     <= '0;
      prod_q   <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      valid_q  <= 1'b0;
      inside_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sort_i_q   <= sort_i_d;
      sort_lim_q <= sort_lim_d;
      idx_q      <= idx_d;
      step_q     <= step_d;
      x_q        <= x_d;
      y_q        <= y_d;
      r_q        <= r_d;
      acc_q      <= acc_d;
      tsum_q     <= tsum_d;
      s_q        <= s_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      fc_q       <= fc_d;
      prod_q     <= prod_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      valid_q    <= valid_d;
      inside_q   <= inside_d;
    end
  end

  assign valid     = valid_q;
  assign is_inside = inside_q;

endmodule

// File: tb/tb_geofence_eval.sv
// Bench for geofence_eval: table of objects with fixed expected results, a result queue,
// plus hand-written reset-abort and back-to-back sequences.
module tb_geofence_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  X, Y;
  logic [10:0] R;
  logic        valid, is_inside;

  always #5 clk = ~clk;

  geofence_eval #(.XY_W(10), .R_W(11), .NPTS(6)) dut (
    .clk(clk), .reset(rst), .X(X), .Y(Y), .R(R), .valid(valid), .is_inside(is_inside)
  );

  typedef struct {
    string name;
    int    x[6];
    int    y[6];
    int    r[6];
    bit    exp;
  } vec_t;

  vec_t  vecs[5];
  bit    exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    lat_ref = -1;
  bit    last_res = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic int fdist(input int ax, input int ay, input int bx, input int by);
    int v = (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input int px[6], input int py[6],
                              input int ox, input int oy, input int fixed_r, input bit e);
    vec_t v;
    v.name = nm;
    for (int k = 0; k < 6; k++) begin
      v.x[k] = px[k];
      v.y[k] = py[k];
      v.r[k] = (fixed_r >= 0) ? fixed_r : fdist(px[k], py[k], ox, oy);
    end
    v.exp = e;
    return v;
  endfunction

  // Drives six samples, one per posedge, starting at the current negedge.
  task automatic feed(input vec_t v, input bit chk_prev);
    for (int k = 0; k < 6; k++) begin
      X = 10'(v.x[k]);
      Y = 10'(v.y[k]);
      R = 11'(v.r[k]);
      @(negedge clk);
      if (k == 0 && chk_prev) begin
        check({v.name, " valid_single_cycle"}, valid, 1'b0);
        check({v.name, " inside_hold"}, is_inside, last_res);
      end
    end
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
  endtask

  task automatic await_result();
    int    lat = 0;
    bit    e;
    string nm;
    while (valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 400) begin
      n_vec++;
      n_bad++;
      $display("FAIL result_timeout: no valid after %0d cycles, expected within 300", lat);
    end else if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_valid: got valid=1, expected none pending");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, " is_inside"}, is_inside, e);
      check({nm, " latency_bound"}, (lat <= 300), 1'b1);
      if (lat_ref < 0) lat_ref = lat;
      else check({nm, " latency_const"}, lat, lat_ref);
      last_res = e;
    end
  endtask

  initial begin
    int fx[6] = '{100, 200, 250, 200, 100, 50};
    int fy[6] = '{0, 0, 87, 173, 173, 87};
    int sx[6] = '{200, 100, 50, 250, 100, 200};
    int sy[6] = '{173, 0, 87, 87, 173, 0};
    int cx[6] = '{300, 300, 300, 300, 300, 300};

    vecs[0] = mk("T1_inside", fx, fy, 150, 87, 100, 1'b1);
    vecs[1] = mk("T2_outside", fx, fy, 600, 600, -1, 1'b0);
    vecs[2] = mk("T3_scrambled", sx, sy, 150, 87, 100, 1'b1);
    vecs[3] = mk("T7_far", fx, fy, 1000, 1000, -1, 1'b0);
    vecs[4] = mk("T6_degenerate", cx, cx, 300, 300, 0, 1'b1);

    rst = 1'b1;
    X = '0;
    Y = '0;
    R = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", valid, 1'b0);
    check("reset_is_inside", is_inside, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      feed(vecs[i], i > 0);
      await_result();
    end

    // Abort T2 five cycles into sorting, then a fresh T1 must still be accepted.
    feed(vecs[1], 1'b1);
    repeat (5) @(negedge clk);
    check("T5 no_early_valid", valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("T5 reset_valid", valid, 1'b0);
    check("T5 reset_is_inside", is_inside, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    name_q.delete();
    last_res = 1'b0;
    feed(vecs[0], 1'b0);
    await_result();

    // Back-to-back: second object's first sample on the cycle right after valid.
    feed(vecs[0], 1'b1);
    await_result();
    feed(vecs[1], 1'b1);
    await_result();
    @(negedge clk);
    check("T4 final_valid_single", valid, 1'b0);
    check("T4 final_inside_hold", is_inside, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
    $fatal(1);
  end

endmodule
